// File: rtl/div.sv
// rtl/div.sv - 32-bit signed restoring divider (optional unsigned mode via DIV_UNSIGNED_EN)
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef DIV_UNSIGNED_EN
  input  logic        div_unsigned,
`endif
  input  logic        div_control,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_end,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;    // partial remainder
  logic [31:0] quo_q, quo_d;    // dividend shifts out the top, quotient bits shift in
  logic [31:0] dvs_q, dvs_d;    // divisor magnitude
  logic        sq_q, sq_d;      // quotient sign
  logic        sr_q, sr_d;      // remainder sign (sign of dividend)
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        end_q, end_d;
  logic        zero_q, zero_d;

  logic        uns;
  logic        sa, sb;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_shift, diff;

`ifdef DIV_UNSIGNED_EN
  assign uns = div_unsigned;
`else
  assign uns = 1'b0;
`endif

  // Unsigned operation simply forces both signs to zero, so no magnitude or sign fix applies.
  assign sa        = a[31] & ~uns;
  assign sb        = b[31] & ~uns;
  assign abs_a     = sa ? (32'd0 - a) : a;
  assign abs_b     = sb ? (32'd0 - b) : b;
  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = rem_shift - {1'b0, dvs_q};

  // Next-state and datapath update for the divider FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    end_d   = 1'b0;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_control) begin
          if (b == 32'd0) begin
            end_d   = 1'b1;
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = abs_a;
            dvs_d   = abs_b;
            sr_d    = sa;
            sq_d    = sa ^ sb;
            cnt_d   = 6'd0;
            rem_d   = 32'd0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = sq_q ? (32'd0 - quo_q) : quo_q;
        hi_d    = sr_q ? (32'd0 - rem_q) : rem_q;
        end_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      end_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      end_q   <= end_d;
      zero_q  <= zero_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign div_end  = end_q;
  assign div_zero = zero_q;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - self-checking bench for div against an arithmetic reference model
module tb_div;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        div_unsigned;
  logic        div_control;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_end;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  // last result the model expects the HI/LO outputs to hold
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  div dut (
    .clk         (clk),
    .reset       (reset),
    .a           (a),
    .b           (b),
`ifdef DIV_UNSIGNED_EN
    .div_unsigned(div_unsigned),
`endif
    .div_control (div_control),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_end     (div_end),
    .div_zero    (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder follows dividend.
  task automatic model(input logic [31:0] av, input logic [31:0] bv, input bit uns,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, q64, r64;
    if (uns) begin
      q = av / bv;
      r = av % bv;
    end else begin
      sa  = longint'($signed(av));
      sb  = longint'($signed(bv));
      q64 = sa / sb;
      r64 = sa % sb;
      q   = q64[31:0];
      r   = r64[31:0];
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input bit uns, input bit hold);
    logic [31:0] q, r;
    int lat, pulses;
    logic zero_seen;
    @(negedge clk);
    a = av;
    b = bv;
    div_unsigned = uns;
    div_control = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) div_control = 1'b0;
    a = $urandom;
    b = $urandom;
    if (bv == 32'd0) begin
      chk({tag, " zero end"}, {31'd0, div_end}, 32'd1);
      chk({tag, " zero flag"}, {31'd0, div_zero}, 32'd1);
      chk({tag, " zero hi held"}, hi_out, exp_hi);
      chk({tag, " zero lo held"}, lo_out, exp_lo);
      div_control = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " zero end pulse"}, {31'd0, div_end}, 32'd0);
      chk({tag, " zero flag clr"}, {31'd0, div_zero}, 32'd0);
    end else begin
      model(av, bv, uns, q, r);
      lat = 0;
      pulses = 0;
      zero_seen = 1'b0;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk);
        #1;
        if (div_end) begin
          pulses++;
          if (lat == 0) lat = i;
          zero_seen = div_zero;
          div_control = 1'b0;
        end
      end
      div_control = 1'b0;
      chk({tag, " latency"}, lat, 32'd33);
      chk({tag, " pulses"}, pulses, 32'd1);
      chk({tag, " zero flag"}, {31'd0, zero_seen}, 32'd0);
      chk({tag, " lo"}, lo_out, q);
      chk({tag, " hi"}, hi_out, r);
      exp_lo = q;
      exp_hi = r;
    end
  endtask

  initial begin
    reset = 1'b0;
    a = 32'd0;
    b = 32'd0;
    div_unsigned = 1'b0;
    div_control = 1'b0;
    #22;
    chk("reset hi", hi_out, 32'd0);
    chk("reset lo", lo_out, 32'd0);
    chk("reset end", {31'd0, div_end}, 32'd0);
    chk("reset zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_div("100/7", 32'd100, 32'd7, 1'b0, 1'b0);
    chk("100/7 const lo", lo_out, 32'd14);
    chk("100/7 const hi", hi_out, 32'd2);
    run_div("-100/7", 32'hFFFFFF9C, 32'd7, 1'b0, 1'b0);
    chk("-100/7 const lo", lo_out, 32'hFFFFFFF2);
    chk("-100/7 const hi", hi_out, 32'hFFFFFFFE);
    run_div("100/-7", 32'd100, 32'hFFFFFFF9, 1'b0, 1'b0);
    chk("100/-7 const lo", lo_out, 32'hFFFFFFF2);
    chk("100/-7 const hi", hi_out, 32'd2);
    run_div("5/0", 32'd5, 32'd0, 1'b0, 1'b0);
    run_div("ovf hold", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    chk("ovf const lo", lo_out, 32'h80000000);
    chk("ovf const hi", hi_out, 32'd0);
    run_div("0/5", 32'd0, 32'd5, 1'b0, 1'b0);
    run_div("min/1", 32'h80000000, 32'd1, 1'b0, 1'b0);
    run_div("-1/max", 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0);

    // abort a division partway through CALC
    @(negedge clk);
    a = 32'd1000;
    b = 32'd3;
    div_control = 1'b1;
    @(posedge clk);
    #1;
    div_control = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("abort hi", hi_out, 32'd0);
    chk("abort lo", lo_out, 32'd0);
    chk("abort end", {31'd0, div_end}, 32'd0);
    chk("abort zero", {31'd0, div_zero}, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      chk("abort no end", {31'd0, div_end}, 32'd0);
    end
    run_div("9/2", 32'd9, 32'd2, 1'b0, 1'b0);
    chk("9/2 const lo", lo_out, 32'd4);
    chk("9/2 const hi", hi_out, 32'd1);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i < 4) ? $urandom : $urandom_range(1, 1000);
      if (i[0]) rb = 32'd0 - rb;
      if (rb == 32'd0) rb = 32'd3;
      run_div("rand signed", ra, rb, 1'b0, 1'b0);
    end

`ifdef DIV_UNSIGNED_EN
    run_div("uns fffffffe/2", 32'hFFFFFFFE, 32'd2, 1'b1, 1'b0);
    chk("uns const lo", lo_out, 32'h7FFFFFFF);
    chk("uns const hi", hi_out, 32'd0);
    run_div("sgn fffffffe/2", 32'hFFFFFFFE, 32'd2, 1'b0, 1'b0);
    chk("sgn const lo", lo_out, 32'hFFFFFFFF);
    chk("sgn const hi", hi_out, 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom | 32'd1;
      run_div("rand unsigned", ra, rb, 1'b1, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
